// File: rtl/ram_burst_pkg.sv
// Shared types and default sizes for the RAM burst controller.
// Optional feature macro: RAM_BURST_WRAP_EN (address wrap instead of rejecting
// bursts that would run past the top of the RAM).
package ram_burst_pkg;

   // Burst controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 8;
   localparam int DEF_RD_LAT = 1;
   localparam int RAM_DEPTH  = 1 << DEF_ADDR_W;

endpackage

// File: rtl/ram_rd_buf.sv
// Small synchronous FIFO that absorbs RAM read data so the read stream can be
// back-pressured. Depth is sized by the caller to the read-credit limit.
module ram_rd_buf #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 2,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Storage array: written on push, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; flush empties the buffer
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst access controller in front of a single-port synchronous RAM.
// One command (direction, start address, length) becomes a run of per-byte
// RAM accesses. Reads are credit-limited so a small buffer covers the RAM's
// fixed read latency under downstream backpressure.
// Optional feature macro: RAM_BURST_WRAP_EN.
//
// Handshakes: every valid/ready pair transfers exactly one item on a rising
// edge where both are high; valid never depends on ready of the same channel,
// and the data fields are meaningful only while valid is high.
module ram_burst_ctrl
   import ram_burst_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              done,
   output logic              cmd_err,
   output state_t            dbg_state
);

   localparam int BUF_DEPTH = RD_LAT + 1;
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

   state_t              state;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W:0]      iss_rem;   // beats still to issue / write
   logic [LEN_W:0]      pop_rem;   // read beats still to hand downstream
   logic [RD_LAT-1:0]   vld_sr;    // marks RAM reads in flight
   logic [CNT_W-1:0]    outstanding;
   logic [CNT_W-1:0]    buf_count;
   logic                issue;
   logic                pop;
   logic                overflow;
   logic [LEN_W:0]      beats;

   assign beats = (LEN_W+1)'(cmd_len) + (LEN_W+1)'(1);

`ifdef RAM_BURST_WRAP_EN
   assign overflow = 1'b0;
`else
   logic [ADDR_W:0] end_addr;
   assign end_addr = {1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len);
   assign overflow = end_addr[ADDR_W];
`endif

   // Count reads in flight; a read may issue while in-flight plus buffered
   // stays within the buffer depth, counting a pop in this cycle as freed
   always_comb begin
      int used;
      outstanding = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         outstanding = outstanding + CNT_W'(vld_sr[i]);
      end
      used  = int'(outstanding) + int'(buf_count);
      issue = (state == READ) && (used < BUF_DEPTH + int'(pop));
   end

   assign rd_valid  = (buf_count != '0);
   assign pop       = rd_valid && rd_ready;
   assign cmd_ready = (state == IDLE) && !done && !cmd_err;
   assign wr_ready  = (state == WRITE);
   assign busy      = (state != IDLE);
   assign ram_we    = reset && (state == WRITE) && wr_valid;
   assign ram_addr  = addr;
   assign ram_din   = wr_data;
   assign dbg_state = state;

   // Burst FSM: command latch, address walk, beat counting, status pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         addr    <= '0;
         iss_rem <= '0;
         pop_rem <= '0;
         done    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  if (overflow) begin
                     cmd_err <= 1'b1;
                  end else begin
                     addr    <= cmd_addr;
                     iss_rem <= beats;
                     pop_rem <= beats;
                     state   <= cmd_write ? WRITE : READ;
                  end
               end
            end
            WRITE: begin
               if (wr_valid) begin
                  addr    <= addr + ADDR_W'(1);
                  iss_rem <= iss_rem - (LEN_W+1)'(1);
                  if (iss_rem == (LEN_W+1)'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  addr    <= addr + ADDR_W'(1);
                  iss_rem <= iss_rem - (LEN_W+1)'(1);
                  if (iss_rem == (LEN_W+1)'(1)) state <= DRAIN;
               end
               if (pop) pop_rem <= pop_rem - (LEN_W+1)'(1);
            end
            DRAIN: begin
               if (pop) begin
                  pop_rem <= pop_rem - (LEN_W+1)'(1);
                  if (pop_rem == (LEN_W+1)'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-latency tag pipe: the last stage marks ram_dout as valid read data
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_sr <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_sr[i] <= vld_sr[i-1];
         end
         vld_sr[0] <= issue;
      end
   end

   ram_rd_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (BUF_DEPTH)
   ) u_rd_buf (
      .clk   (clk),
      .flush (!reset),
      .push  (vld_sr[RD_LAT-1]),
      .din   (ram_dout),
      .pop   (pop),
      .dout  (rd_data),
      .count (buf_count)
   );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed and randomized bench for ram_burst_ctrl with an attached RAM model
// and a reference memory image used to predict every read beat.
module tb_ram_burst_ctrl;
   import ram_burst_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid, rd_ready;
   logic [7:0]  rd_data;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_din, ram_dout;
   logic        busy, done, cmd_err;
   state_t      dbg_state;

   ram_burst_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .busy      (busy),
      .done      (done),
      .cmd_err   (cmd_err),
      .dbg_state (dbg_state)
   );

   // ---------------- RAM model: sync write, registered read ----------------
   logic [7:0] ram [0:4095];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   // ---------------- scoreboard ----------------
   logic [7:0] ref_mem [0:4095];
   logic [7:0] wdata [0:255];
   logic [7:0] exp_q [$];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_cmd(input logic w, input logic [11:0] a, input logic [7:0] l);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [11:0] a, input int len, input int gap_at, input int gap_n);
      int i, idle;
      logic [11:0] exp_a;
      send_cmd(1'b1, a, 8'(len));
      i = 0; idle = 0; exp_a = a;
      while (i <= len) begin
         if (i == gap_at && idle < gap_n) begin
            wr_valid = 1'b0;
            wr_data  = 8'($urandom);
            idle++;
         end else begin
            wr_valid = 1'b1;
            wr_data  = wdata[i];
         end
         @(negedge clk);
         chk("wr_ready", wr_ready, 1);
         chk("wr_busy", busy, 1);
         chk("wr_rd_valid", rd_valid, 0);
         chk("wr_ram_we", ram_we, wr_valid);
         chk("wr_ram_addr", ram_addr, exp_a);
         if (wr_valid) chk("wr_ram_din", ram_din, wdata[i]);
         @(posedge clk); #1;
         if (wr_valid) begin
            ref_mem[exp_a] = wdata[i];
            exp_a = exp_a + 12'd1;
            i++;
         end
      end
      wr_valid = 1'b0;
      @(negedge clk);
      chk("wr_done", done, 1);
      chk("wr_busy_end", busy, 0);
      chk("wr_cmd_ready_gap", cmd_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_done_width", done, 0);
      chk("wr_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
   endtask

   // mode 0: rd_ready always 1, 1: toggling, 2: random
   task automatic read_burst(input logic [11:0] a, input int len, input int mode);
      int cyc, first, popped;
      logic [7:0] e;
      send_cmd(1'b0, a, 8'(len));
      for (int k = 0; k <= len; k++) exp_q.push_back(ref_mem[a + 12'(k)]);
      cyc = 1; first = -1; popped = 0;
      while (popped <= len && cyc < 2000) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (cyc % 2 == 1);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         chk("rd_wr_ready", wr_ready, 0);
         chk("rd_ram_we", ram_we, 0);
         chk("rd_busy", busy, 1);
         chk("rd_done_early", done, 0);
         if (rd_valid && first < 0) first = cyc;
         if (rd_valid && rd_ready) begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e);
            popped++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rd_ready = 1'b0;
      chk("rd_beats", popped, len + 1);
      if (mode == 0) chk("rd_first_latency", first, 3);
      @(negedge clk);
      chk("rd_done", done, 1);
      chk("rd_busy_end", busy, 0);
      chk("rd_valid_end", rd_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rd_done_width", done, 0);
      @(posedge clk); #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int len, a, gat, gn;
      reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ram_we", ram_we, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_ram_addr", ram_addr, 0);
      @(posedge clk); #1;

      // write 100..115 to 0..15, then read back two ways
      for (int i = 0; i < 16; i++) wdata[i] = 8'(100 + i);
      write_burst(12'd0, 15, -1, 0);
      read_burst(12'd0, 15, 0);
      read_burst(12'd0, 15, 1);

      // top-of-RAM burst
      for (int i = 0; i < 4; i++) wdata[i] = 8'(1 + i);
`ifdef RAM_BURST_WRAP_EN
      write_burst(12'd4094, 3, -1, 0);
      read_burst(12'd4094, 3, 0);
`else
      wr_valid = 1'b1;
      wr_data  = 8'd1;
      send_cmd(1'b1, 12'd4094, 8'd3);
      @(negedge clk);
      chk("err_pulse", cmd_err, 1);
      chk("err_busy", busy, 0);
      chk("err_ram_we", ram_we, 0);
      chk("err_wr_ready", wr_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_width", cmd_err, 0);
      chk("err_no_done", done, 0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      read_burst(12'd4094, 1, 0);
      read_burst(12'd0, 1, 0);
`endif

      // reset in the middle of a 16-beat read
      send_cmd(1'b0, 12'd0, 8'd15);
      for (int k = 0; k < 16; k++) exp_q.push_back(ref_mem[k]);
      rd_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rd_valid) chk("mid_rd_data", rd_data, exp_q.pop_front());
         @(posedge clk); #1;
      end
      exp_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      rd_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_rd_valid", rd_valid, 0);
         chk("mid_rst_busy", busy, 0);
         chk("mid_rst_done", done, 0);
         @(posedge clk); #1;
      end
      read_burst(12'd5, 0, 0);

      // write with a 3-cycle wr_valid gap, then read back
      for (int i = 0; i < 8; i++) wdata[i] = 8'(200 + i);
      write_burst(12'd200, 7, 3, 3);
      read_burst(12'd200, 7, 0);

      // randomized bursts
      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(0, 20);
         a   = $urandom_range(0, 4095 - len);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= len; i++) wdata[i] = 8'($urandom);
            gat = $urandom_range(0, len);
            gn  = $urandom_range(0, 2);
            write_burst(12'(a), len, gat, gn);
         end else begin
            read_burst(12'(a), len, $urandom_range(0, 2));
         end
      end
      read_burst(12'd200, 7, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
